llc_assoc: RTL
==============

LLC_ASSOC -- requirements
Module: llc_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity (power of 2, at least 1).
REQ-002 SHALL have parameter SETS, default 32, set count (power of 2).
REQ-003 SHALL have parameter BYTES_PER_LINE, default 64, line size.
REQ-004 SHALL have parameter AXI_DATA_WIDTH, default 64, refill beat width; BEATS = BYTES_PER_LINE*8/AXI_DATA_WIDTH.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have ports S_R_ADDR in 64 request address; S_R_ADDR_VALID in 1; S_R_ADDR_READY out 1.
REQ-008 SHALL have ports S_R_DATA out BYTES_PER_LINE*8 line data; S_R_DATA_VALID out 1.
REQ-009 SHALL have port S_FLUSH  in  1  invalidate-all request.
REQ-010 SHALL have AXI read ports m_axi_araddr out 64; m_axi_arlen out 8; m_axi_arvalid out 1; m_axi_arready in 1; m_axi_rdata in AXI_DATA_WIDTH; m_axi_rvalid in 1; m_axi_rlast in 1; m_axi_rready out 1.

Function
REQ-011 SHALL implement FSM states IDLE, AR, FILL, RESP.
REQ-012 SHALL drive S_R_ADDR_READY=1 only in IDLE with S_FLUSH=0; a request is accepted on VALID&&READY.
REQ-013 On an accepted hit (tag match and valid in any way of the set), SHALL assert S_R_DATA_VALID for exactly one cycle, the cycle after acceptance, with the hit line on S_R_DATA, and stay in IDLE.
REQ-014 On an accepted miss, SHALL latch the address and go to AR.
REQ-015 In AR, SHALL hold m_axi_arvalid=1, m_axi_araddr = latched address with offset bits zeroed, and m_axi_arlen=BEATS-1, all stable until m_axi_arready; then go to FILL.
REQ-016 In FILL, SHALL hold m_axi_rready=1; beat k (0-based) writes line bits [k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] of the victim way; beat counter SHALL be log2(BEATS) bits and wrap.
REQ-017 On the beat with m_axi_rlast, SHALL write that beat, set victim valid=1 and tag, and go to RESP.
REQ-018 In RESP, SHALL assert S_R_DATA_VALID for one cycle with the filled line, then go to IDLE.
REQ-019 Victim SHALL be the lowest-index invalid way; if none, the per-set round-robin pointer, which advances (mod WAYS) on each completed fill of that set.
REQ-020 While a way is being filled, its valid bit SHALL be 0.
REQ-021 S_FLUSH in IDLE SHALL clear all valid bits next cycle and leave RR pointers unchanged; it has priority over a simultaneous request, which is not accepted.
REQ-022 S_FLUSH outside IDLE SHALL be ignored.
REQ-023 m_axi_arvalid=0 outside AR; m_axi_rready=0 outside FILL; S_R_DATA_VALID=0 except as in REQ-013/018.

Reset
REQ-024 With reset=0 at a clock edge, SHALL enter IDLE, clear all valid bits, RR pointers and beat counter, and drive arvalid, rready and S_R_DATA_VALID to 0, including mid-AR or mid-FILL (outstanding burst abandoned).
REQ-025 Data and tag arrays SHALL NOT require reset.

Configuration
REQ-026 With LLC_ASSOC_PERF_CNT_EN defined, SHALL add outputs hit_count and miss_count (32 bits, saturating, reset to 0), incremented once per accepted hit or miss.
REQ-027 Without LLC_ASSOC_PERF_CNT_EN, those ports and counters SHALL be absent.

Structure
REQ-028 Package llc_pkg SHALL hold the FSM state enum, address-split width functions and the line struct (valid, tag, data).
REQ-029 Sub-module llc_victim_sel SHALL compute the victim way from per-set valid bits and the RR pointer (combinational).

Verification
REQ-030 Cold miss: reset, request 0x1000 -> arvalid with araddr 0x1000, arlen 7; 8 beats D0..D7, rlast on the 8th -> RESP data = {D7..D0}, then VALID=1 one cycle.
REQ-031 Hit: re-request 0x1008 -> S_R_DATA_VALID the next cycle, same line, no AR.
REQ-032 Replacement (WAYS=2, SETS=32): fill 0x1000, 0x1800, 0x2000 (all set 0) -> third fill evicts way 0; 0x1800 still hits, 0x1000 misses.
REQ-033 Flush: S_FLUSH and a request in the same IDLE cycle -> READY=0; afterwards 0x1008 misses.
REQ-034 Backpressure: arready low for 5 cycles -> arvalid and araddr stable throughout; rvalid gaps in FILL -> correct beat placement.
REQ-035 Reset mid-FILL after 3 beats -> IDLE, rready=0, line not valid; next request misses.

Source files
------------

// File: rtl/llc_pkg.sv
// Shared types and address-split helpers for the set-associative line cache.
package llc_pkg;

  localparam int unsigned LLC_ADDR_W     = 64;
  localparam int unsigned LLC_MAX_LINE_W = 2048;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } llc_state_e;

  // Widest supported line; narrower geometries zero-extend into it.
  typedef struct packed {
    logic                      valid;
    logic [LLC_ADDR_W-1:0]     tag;
    logic [LLC_MAX_LINE_W-1:0] data;
  } llc_line_t;

  function automatic int unsigned llc_off_w(input int unsigned bytes_per_line);
    return $clog2(bytes_per_line);
  endfunction

  function automatic int unsigned llc_idx_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned llc_tag_w(input int unsigned bytes_per_line,
                                            input int unsigned sets);
    return LLC_ADDR_W - llc_off_w(bytes_per_line) - llc_idx_bits(sets);
  endfunction

endpackage

// File: rtl/llc_assoc_if.sv
// Request/response port plus AXI read channel of the line cache, bundled as one interface.
interface llc_assoc_if
  import llc_pkg::*;
#(
  parameter int unsigned LINE_W         = 512,
  parameter int unsigned AXI_DATA_WIDTH = 64
) ();

  logic [LLC_ADDR_W-1:0]     S_R_ADDR;
  logic                      S_R_ADDR_VALID;
  logic                      S_R_ADDR_READY;
  logic [LINE_W-1:0]         S_R_DATA;
  logic                      S_R_DATA_VALID;
  logic                      S_FLUSH;

  logic [LLC_ADDR_W-1:0]     m_axi_araddr;
  logic [7:0]                m_axi_arlen;
  logic                      m_axi_arvalid;
  logic                      m_axi_arready;
  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata;
  logic                      m_axi_rvalid;
  logic                      m_axi_rlast;
  logic                      m_axi_rready;

  // Cache side: accepts requests, masters the AXI read channel.
  modport slave (
    input  S_R_ADDR, S_R_ADDR_VALID, S_FLUSH,
           m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rlast,
    output S_R_ADDR_READY, S_R_DATA, S_R_DATA_VALID,
           m_axi_araddr, m_axi_arlen, m_axi_arvalid, m_axi_rready
  );

  // Requester and memory side.
  modport master (
    output S_R_ADDR, S_R_ADDR_VALID, S_FLUSH,
           m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rlast,
    input  S_R_ADDR_READY, S_R_DATA, S_R_DATA_VALID,
           m_axi_araddr, m_axi_arlen, m_axi_arvalid, m_axi_rready
  );

endinterface

// File: rtl/llc_victim_sel.sv
// Victim way choice: lowest-index invalid way, else the set's round-robin pointer.
module llc_victim_sel #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned WAY_W = 1
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [WAY_W-1:0] rr_ptr,
  output logic [WAY_W-1:0] victim
);

  // Scan from the top so the lowest invalid way is the last one written.
  always_comb begin
    victim = rr_ptr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/llc_assoc.sv
// Blocking set-associative line cache with AXI burst refill.
// Optional LLC_ASSOC_PERF_CNT_EN adds saturating hit_count/miss_count outputs.
module llc_assoc
  import llc_pkg::*;
#(
  parameter int unsigned WAYS           = 2,
  parameter int unsigned SETS           = 32,
  parameter int unsigned BYTES_PER_LINE = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  llc_assoc_if.slave  bus
`ifdef LLC_ASSOC_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned LINE_W   = BYTES_PER_LINE * 8;
  localparam int unsigned BEATS    = LINE_W / AXI_DATA_WIDTH;
  localparam int unsigned OFF_W    = llc_off_w(BYTES_PER_LINE);
  localparam int unsigned IDX_BITS = llc_idx_bits(SETS);
  localparam int unsigned IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int unsigned TAG_W    = llc_tag_w(BYTES_PER_LINE, SETS);
  localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  llc_state_e state_q, state_d;

  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAY_W-1:0]    rr_q    [SETS];
  logic [BEAT_W-1:0]   beat_q;
  logic                hit_vld_q;

  logic [TAG_W-1:0]      tag_q  [SETS][WAYS];
  logic [LINE_W-1:0]     data_q [SETS][WAYS];
  logic [LLC_ADDR_W-1:0] addr_q;
  logic [WAY_W-1:0]      victim_q;
  logic [LINE_W-1:0]     rdata_q;

  logic [IDX_W-1:0] req_idx, idx_q;
  logic [TAG_W-1:0] req_tag;
  llc_line_t        way_line [WAYS];
  logic             hit;
  logic [WAY_W-1:0] hit_way, victim;
  logic             req_ready, req_fire, flush_fire, fill_beat;

  function automatic logic [WAY_W-1:0] rr_next(input logic [WAY_W-1:0] p);
    if (WAYS == 1) return '0;
    return (p == WAY_W'(WAYS - 1)) ? '0 : p + WAY_W'(1);
  endfunction

  assign req_idx = IDX_W'(bus.S_R_ADDR >> OFF_W) & IDX_W'(SETS - 1);
  assign req_tag = TAG_W'(bus.S_R_ADDR >> (OFF_W + IDX_BITS));
  assign idx_q   = IDX_W'(addr_q >> OFF_W) & IDX_W'(SETS - 1);

  // Lookup stage: every way of the addressed set, compared in parallel
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_line[w].valid = valid_q[req_idx][w];
      way_line[w].tag   = LLC_ADDR_W'(tag_q[req_idx][w]);
      way_line[w].data  = LLC_MAX_LINE_W'(data_q[req_idx][w]);
      if (!hit && way_line[w].valid && (way_line[w].tag == LLC_ADDR_W'(req_tag))) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  llc_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_victim_sel (
    .valid  (valid_q[req_idx]),
    .rr_ptr (rr_q[req_idx]),
    .victim (victim)
  );

  always_comb begin
    state_d            = state_q;
    req_ready          = 1'b0;
    flush_fire         = 1'b0;
    bus.m_axi_arvalid  = 1'b0;
    bus.m_axi_rready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready  = !bus.S_FLUSH;
        flush_fire = bus.S_FLUSH;
        if (req_ready && bus.S_R_ADDR_VALID && !hit) state_d = AR;
      end
      AR: begin
        bus.m_axi_arvalid = 1'b1;
        if (bus.m_axi_arready) state_d = FILL;
      end
      FILL: begin
        bus.m_axi_rready = 1'b1;
        if (bus.m_axi_rvalid && bus.m_axi_rlast) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_fire  = req_ready && bus.S_R_ADDR_VALID;
  assign fill_beat = (state_q == FILL) && bus.m_axi_rvalid;

  assign bus.S_R_ADDR_READY = req_ready;
  assign bus.m_axi_araddr   = addr_q & ~LLC_ADDR_W'(BYTES_PER_LINE - 1);
  assign bus.m_axi_arlen    = 8'(BEATS - 1);
  assign bus.S_R_DATA_VALID = hit_vld_q || (state_q == RESP);
  assign bus.S_R_DATA       = (state_q == RESP) ? data_q[idx_q][victim_q] : rdata_q;

  // Control state: FSM, valid bits, round-robin pointers, beat counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      hit_vld_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      hit_vld_q <= req_fire && hit;
      if (flush_fire) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (req_fire && !hit) begin
        valid_q[req_idx][victim] <= 1'b0;
      end
      if ((state_q == AR) && bus.m_axi_arready) beat_q <= '0;
      if (fill_beat) begin
        beat_q <= beat_q + BEAT_W'(1);
        if (bus.m_axi_rlast) begin
          valid_q[idx_q][victim_q] <= 1'b1;
          rr_q[idx_q]              <= rr_next(rr_q[idx_q]);
        end
      end
    end
  end

  // Data state: arrays, latched miss context and hit response register
  always_ff @(posedge clk) begin
    if (req_fire) begin
      addr_q   <= bus.S_R_ADDR;
      victim_q <= victim;
    end
    if (req_fire && hit) rdata_q <= LINE_W'(way_line[hit_way].data);
    if (fill_beat) begin
      data_q[idx_q][victim_q][beat_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= bus.m_axi_rdata;
      if (bus.m_axi_rlast) tag_q[idx_q][victim_q] <= TAG_W'(addr_q >> (OFF_W + IDX_BITS));
    end
  end

`ifdef LLC_ASSOC_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (req_fire) begin
      if (hit) hit_count  <= sat_inc(hit_count);
      else     miss_count <= sat_inc(miss_count);
    end
  end
`endif

endmodule
